// File: rtl/multi_channel_scoreboard.sv
// multi_channel_scoreboard: tracks one tagged word per FIFO channel through the arbitrated FIFO bank.
// Define SB_PROTOCOL_CHECK_EN to also flag overflow, underflow and multi-grant pops in err.
module multi_channel_scoreboard #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int CNTW   = $clog2(DEPTH + 1),
  parameter bit REARM  = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       push,
  input  logic [NUM_CH-1:0]       pop,
  input  logic [NUM_CH*WIDTH-1:0] flat_data_in,
  input  logic [WIDTH-1:0]        data_out,
  output logic [NUM_CH-1:0]       done,
  output logic [NUM_CH-1:0]       err,
  output logic                    prop_signal
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam logic [CNTW-1:0] FULL = CNTW'(DEPTH);
  localparam logic [CNTW-1:0] ONE  = CNTW'(1);

`ifdef SB_PROTOCOL_CHECK_EN
  logic w_multi_pop;
  // More than one grant in a cycle makes the shared data_out ambiguous
  assign w_multi_pop = (pop & (pop - NUM_CH'(1))) != '0;
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_t          r_state, w_state_nxt;
    logic [CNTW-1:0] r_occ, w_occ_nxt;
    logic [CNTW-1:0] r_ahead, w_ahead_nxt;
    logic [WIDTH-1:0] r_tag, w_tag_nxt;
    logic            r_err, w_err_nxt;
    logic [WIDTH-1:0] w_din;
    logic            w_full, w_empty;

    assign w_din   = flat_data_in[c*WIDTH +: WIDTH];
    assign w_full  = (r_occ == FULL);
    assign w_empty = (r_occ == '0);

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_state <= S_IDLE;
        r_occ   <= '0;
        r_ahead <= '0;
        r_tag   <= '0;
        r_err   <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_occ   <= w_occ_nxt;
        r_ahead <= w_ahead_nxt;
        r_tag   <= w_tag_nxt;
        r_err   <= w_err_nxt;
      end
    end

    always_comb begin
      w_state_nxt = r_state;
      w_occ_nxt   = r_occ;
      w_ahead_nxt = r_ahead;
      w_tag_nxt   = r_tag;
      w_err_nxt   = r_err;

      if (push[c] && !pop[c] && !w_full)
        w_occ_nxt = r_occ + ONE;
      else if (pop[c] && !push[c] && !w_empty)
        w_occ_nxt = r_occ - ONE;

      unique case (r_state)
        S_IDLE: begin
          if (start[c] && push[c]) begin
            w_state_nxt = S_WAIT;
            w_tag_nxt   = w_din;
            // A same-cycle pop removes one of the entries ahead of the tagged word
            w_ahead_nxt = (pop[c] && !w_empty) ? r_occ - ONE : r_occ;
          end
        end
        S_WAIT: begin
          if (pop[c]) begin
            if (r_ahead != '0) begin
              w_ahead_nxt = r_ahead - ONE;
            end else begin
              w_state_nxt = S_DONE;
              if (data_out != r_tag) w_err_nxt = 1'b1;
            end
          end
        end
        S_DONE: begin
          if (REARM) w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase

`ifdef SB_PROTOCOL_CHECK_EN
      if ((push[c] && w_full) || (pop[c] && w_empty) || (pop[c] && w_multi_pop))
        w_err_nxt = 1'b1;
`endif
    end

    assign done[c] = (r_state == S_DONE);
    assign err[c]  = r_err;
  end

  assign prop_signal = |err;

endmodule

// File: tb/tb_multi_channel_scoreboard.sv
// Bench for multi_channel_scoreboard: one terminal-DONE and one rearming instance share stimulus,
// checked every cycle against a queue-based model of the FIFO bank with per-instance tag marks.
module tb_multi_channel_scoreboard;
  localparam int NUM_CH = 4;
  localparam int WIDTH  = 8;
  localparam int DEPTH  = 8;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_CH-1:0]       start, push, pop;
  logic [NUM_CH*WIDTH-1:0] flat_data_in;
  logic [WIDTH-1:0]        data_out;
  logic [NUM_CH-1:0]       done0, err0, done1, err1;
  logic                    prop0, prop1;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  multi_channel_scoreboard #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .DEPTH(DEPTH), .REARM(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .push(push), .pop(pop),
    .flat_data_in(flat_data_in), .data_out(data_out),
    .done(done0), .err(err0), .prop_signal(prop0)
  );

  multi_channel_scoreboard #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .DEPTH(DEPTH), .REARM(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .push(push), .pop(pop),
    .flat_data_in(flat_data_in), .data_out(data_out),
    .done(done1), .err(err1), .prop_signal(prop1)
  );

  // Model: FIFO contents per channel; each entry carries one mark bit per instance
  // saying "this is the word that instance tagged".
  logic [WIDTH-1:0]  qd [NUM_CH][$];
  logic [1:0]        qm [NUM_CH][$];
  int                mst [2][NUM_CH];   // 0 idle, 1 tracking, 2 checked
  logic [NUM_CH-1:0] merr [2];

  function automatic logic [31:0] pk(input int c, input logic [WIDTH-1:0] v);
    return 32'(v) << (c * WIDTH);
  endfunction

  function automatic logic [NUM_CH-1:0] exp_done(input int d);
    logic [NUM_CH-1:0] r;
    r = '0;
    for (int c = 0; c < NUM_CH; c++) r[c] = (mst[d][c] == 2);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string name);
    check({name, ":done0"}, 32'(done0), 32'(exp_done(0)));
    check({name, ":err0"},  32'(err0),  32'(merr[0]));
    check({name, ":prop0"}, 32'(prop0), 32'(|merr[0]));
    check({name, ":done1"}, 32'(done1), 32'(exp_done(1)));
    check({name, ":err1"},  32'(err1),  32'(merr[1]));
    check({name, ":prop1"}, 32'(prop1), 32'(|merr[1]));
  endtask

  task automatic model_clear();
    for (int c = 0; c < NUM_CH; c++) begin
      qd[c].delete();
      qm[c].delete();
      mst[0][c] = 0;
      mst[1][c] = 0;
    end
    merr[0] = '0;
    merr[1] = '0;
  endtask

  task automatic model_edge();
    int npop;
    npop = $countones(pop);
    for (int c = 0; c < NUM_CH; c++) begin
      int               sz;
      bit               popped;
      logic [WIDTH-1:0] pdata;
      logic [1:0]       pmark;
      logic [1:0]       nmark;
      sz     = qd[c].size();
      popped = 0;
      pdata  = '0;
      pmark  = '0;
      nmark  = '0;
`ifdef SB_PROTOCOL_CHECK_EN
      if ((push[c] && sz == DEPTH) || (pop[c] && sz == 0) || (pop[c] && npop > 1)) begin
        merr[0][c] = 1'b1;
        merr[1][c] = 1'b1;
      end
`endif
      if (pop[c] && sz > 0) begin
        pdata  = qd[c].pop_front();
        pmark  = qm[c].pop_front();
        popped = 1;
      end
      for (int d = 0; d < 2; d++) begin
        int prev;
        prev = mst[d][c];
        if (prev == 0 && start[c] && push[c]) begin
          nmark[d]  = 1'b1;
          mst[d][c] = 1;
        end else if (prev == 1 && popped && pmark[d]) begin
          if (data_out !== pdata) merr[d][c] = 1'b1;
          mst[d][c] = 2;
        end else if (prev == 2 && d == 1) begin
          mst[d][c] = 0;
        end
      end
      if (push[c] && (sz - int'(popped)) < DEPTH) begin
        qd[c].push_back(flat_data_in[c*WIDTH +: WIDTH]);
        qm[c].push_back(nmark);
      end
    end
  endtask

  // Drives one cycle; data_out shows the head of the lowest popping channel, optionally corrupted.
  task automatic cycle(input logic [NUM_CH-1:0] st, input logic [NUM_CH-1:0] pu,
                       input logic [NUM_CH-1:0] po, input logic [31:0] din,
                       input logic [WIDTH-1:0] corrupt, input string name);
    start        = st;
    push         = pu;
    pop          = po;
    flat_data_in = din;
    data_out     = '0;
    for (int c = NUM_CH - 1; c >= 0; c--)
      if (po[c] && qd[c].size() > 0) data_out = qd[c][0];
    data_out = data_out ^ corrupt;
    @(posedge clk);
    model_edge();
    #1;
    compare_all(name);
  endtask

  task automatic do_reset(input string name);
    start = '0;
    push  = '0;
    pop   = '0;
    #2;
    rst = 1'b0;
    #1;
    check({name, ":rst_done0"}, 32'(done0), 32'(0));
    check({name, ":rst_err0"},  32'(err0),  32'(0));
    check({name, ":rst_prop0"}, 32'(prop0), 32'(0));
    check({name, ":rst_done1"}, 32'(done1), 32'(0));
    check({name, ":rst_err1"},  32'(err1),  32'(0));
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst          = 1'b0;
    start        = '0;
    push         = '0;
    pop          = '0;
    flat_data_in = '0;
    data_out     = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    rst = 1'b1;

    // Basic in-order check on ch0
    cycle(4'b0000, 4'b0001, 4'b0000, pk(0, 8'h11), 8'h00, "t1_push");
    cycle(4'b0000, 4'b0001, 4'b0000, pk(0, 8'h22), 8'h00, "t1_push");
    cycle(4'b0001, 4'b0001, 4'b0000, pk(0, 8'h33), 8'h00, "t1_tag");
    cycle(4'b0000, 4'b0000, 4'b0001, '0, 8'h00, "t1_pop");
    cycle(4'b0000, 4'b0000, 4'b0001, '0, 8'h00, "t1_pop");
    check("t1_done_early", 32'(done0), 32'(0));
    cycle(4'b0000, 4'b0000, 4'b0001, '0, 8'h00, "t1_pop");
    check("t1_done", 32'(done0), 32'(4'b0001));
    check("t1_err", 32'(err0), 32'(0));
    cycle(4'b0000, 4'b0000, 4'b0000, '0, 8'h00, "t1_idle");
    check("t1_done_hold", 32'(done0), 32'(4'b0001));
    check("t1_rearm_drop", 32'(done1), 32'(0));
    do_reset("t1");

    // Mismatch on the checking pop: 0x33 observed as 0x34
    cycle(4'b0000, 4'b0001, 4'b0000, pk(0, 8'h11), 8'h00, "t2_push");
    cycle(4'b0000, 4'b0001, 4'b0000, pk(0, 8'h22), 8'h00, "t2_push");
    cycle(4'b0001, 4'b0001, 4'b0000, pk(0, 8'h33), 8'h00, "t2_tag");
    cycle(4'b0000, 4'b0000, 4'b0001, '0, 8'h00, "t2_pop");
    cycle(4'b0000, 4'b0000, 4'b0001, '0, 8'h00, "t2_pop");
    cycle(4'b0000, 4'b0000, 4'b0001, '0, 8'h07, "t2_badpop");
    check("t2_err", 32'(err0), 32'(4'b0001));
    check("t2_prop", 32'(prop0), 32'(1));
    repeat (3) cycle(4'b0000, 4'b0000, 4'b0000, '0, 8'h00, "t2_sticky");
    check("t2_prop_sticky", 32'(prop1), 32'(1));
    do_reset("t2");

    // Simultaneous tags on ch1 (occ 0) and ch3 (occ 2), interleaved pops
    cycle(4'b0000, 4'b1000, 4'b0000, pk(3, 8'hA1), 8'h00, "t3_push");
    cycle(4'b0000, 4'b1000, 4'b0000, pk(3, 8'hA2), 8'h00, "t3_push");
    cycle(4'b1010, 4'b1010, 4'b0000, pk(1, 8'hB1) | pk(3, 8'hC3), 8'h00, "t3_tag");
    cycle(4'b0000, 4'b0000, 4'b1000, '0, 8'h00, "t3_pop3");
    cycle(4'b0000, 4'b0000, 4'b0010, '0, 8'h00, "t3_pop1");
    check("t3_done1", 32'(done0), 32'(4'b0010));
    cycle(4'b0000, 4'b0000, 4'b1000, '0, 8'h00, "t3_pop3");
    cycle(4'b0000, 4'b0000, 4'b1000, '0, 8'h00, "t3_pop3");
    check("t3_done13", 32'(done0), 32'(4'b1010));
    check("t3_err", 32'(err0), 32'(0));
    do_reset("t3");

    // Capture at occ=3 with a same-cycle pop: check on the third later pop
    for (int i = 0; i < 3; i++)
      cycle(4'b0000, 4'b0100, 4'b0000, pk(2, 8'(8'h40 + i)), 8'h00, "t4_push");
    cycle(4'b0100, 4'b0100, 4'b0100, pk(2, 8'hD4), 8'h00, "t4_tagpop");
    cycle(4'b0000, 4'b0000, 4'b0100, '0, 8'h00, "t4_pop");
    cycle(4'b0000, 4'b0000, 4'b0100, '0, 8'h00, "t4_pop");
    check("t4_not_yet", 32'(done0), 32'(0));
    cycle(4'b0000, 4'b0000, 4'b0100, '0, 8'h00, "t4_check");
    check("t4_done", 32'(done0), 32'(4'b0100));
    do_reset("t4");

    // Two consecutive tags on ch2; only the rearming instance tracks the second
    cycle(4'b0100, 4'b0100, 4'b0000, pk(2, 8'h5A), 8'h00, "t5_tag");
    cycle(4'b0000, 4'b0000, 4'b0100, '0, 8'h00, "t5_check");
    check("t5_pulse1", 32'(done1), 32'(4'b0100));
    cycle(4'b0000, 4'b0000, 4'b0000, '0, 8'h00, "t5_gap");
    check("t5_gap", 32'(done1), 32'(0));
    cycle(4'b0100, 4'b0100, 4'b0000, pk(2, 8'h6B), 8'h00, "t5_tag2");
    cycle(4'b0000, 4'b0000, 4'b0100, '0, 8'h00, "t5_check2");
    check("t5_pulse2", 32'(done1), 32'(4'b0100));
    cycle(4'b0001, 4'b0001, 4'b0000, pk(0, 8'h77), 8'h00, "t5_wait");
    do_reset("t5");

    // Two grants in one cycle, then overfill ch0
    cycle(4'b0000, 4'b0011, 4'b0000, pk(0, 8'h10) | pk(1, 8'h20), 8'h00, "t6_push");
    cycle(4'b0000, 4'b0000, 4'b0011, '0, 8'h00, "t6_multipop");
    for (int i = 0; i < DEPTH + 1; i++)
      cycle(4'b0000, 4'b0001, 4'b0000, pk(0, 8'(i)), 8'h00, "t6_fill");
    do_reset("t6");

    // Randomized legal traffic, single grant per cycle, occasional corrupted data_out
    for (int n = 0; n < 400; n++) begin
      logic [NUM_CH-1:0] st, pu, po;
      logic [31:0]       din;
      logic [WIDTH-1:0]  cor;
      int                ch;
      st  = NUM_CH'($urandom_range(15));
      din = $urandom;
      pu  = '0;
      po  = '0;
      cor = '0;
      for (int c = 0; c < NUM_CH; c++)
        if (qd[c].size() < DEPTH && $urandom_range(1) == 1) pu[c] = 1'b1;
      ch = $urandom_range(NUM_CH - 1);
      if ($urandom_range(1) == 1 && qd[ch].size() > 0) po[ch] = 1'b1;
      if (po != '0 && $urandom_range(7) == 0) cor = WIDTH'($urandom_range(255, 1));
      cycle(st, pu, po, din, cor, "rand");
      if (n % 100 == 99) do_reset("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multi_channel_scoreboard.md
# multi_channel_scoreboard

Parametrised successor to the single-channel scoreboard: tracks one tagged packet per FIFO channel, on all channels at once, through the arbitrated FIFO bank. Each channel models its FIFO occupancy, captures a tagged word on `start`, counts down the entries ahead of it, and checks the shared arbiter output when the tagged word is popped. Sits beside `arbitrated_fifos` in the formal/sim top. `prop_signal` is the single property output for the checker.

## Interface
- `NUM_CH`, 4: channel count (≥1)
- `WIDTH`, 8: data width
- `DEPTH`, 8: per-channel FIFO depth (≥2)
- `CNTW`, `$clog2(DEPTH+1)`: occupancy/countdown width
- `REARM`, 0: 1 = channel returns from DONE to IDLE and may track again; 0 = DONE is terminal until reset

Ports:
- `clk`  in  1  clock; all state on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `start`  in  NUM_CH  per-channel tag request
- `push`  in  NUM_CH  FIFO push strobes
- `pop`  in  NUM_CH  FIFO pop strobes (arbiter grants)
- `flat_data_in`  in  NUM_CH*WIDTH  channel c data at bits `[(c+1)*WIDTH-1 : c*WIDTH]`
- `data_out`  in  WIDTH  arbiter output, valid in the cycle of any pop
- `done`  out  NUM_CH  channel c tagged word has been checked
- `err`  out  NUM_CH  sticky per-channel mismatch/violation
- `prop_signal`  out  1  `|err`

## Operation
- Per channel c: occupancy `occ[c]` (CNTW), countdown `ahead[c]` (CNTW), captured word `tag[c]` (WIDTH), state IDLE / WAIT / DONE.
- `occ`: +1 on push only, −1 on pop only, unchanged on both; saturates at 0 and DEPTH (pop at 0 and push at DEPTH are ignored).
- IDLE → WAIT when `start[c] & push[c]`: `tag[c] <= data_in[c]`; `ahead[c] <= occ[c] - (pop[c] && occ[c]!=0)`. `start` without push: no effect.
- WAIT, `pop[c]` with `ahead[c]!=0`: `ahead[c]` −1. Pushes never change `ahead`.
- WAIT, `pop[c]` with `ahead[c]==0`: compare `data_out` to `tag[c]`; mismatch sets `err[c]`; → DONE.
- DONE: `done[c]=1`. If REARM=1, → IDLE next cycle (`done` high exactly one cycle); `start` in DONE is ignored.
- `err[c]` sticky until reset; `err` never clears on rearm.
- Channels independent; a simultaneous tag on every channel is legal.

## Timing
- Reset (rst=0, any time, async): all states IDLE, `occ`/`ahead`/`tag`/`done`/`err`=0, `prop_signal`=0. Mid-track reset discards the tag.
- `done`, `err`, `prop_signal` registered: visible the cycle after the checking pop.
- Minimum tag-to-check latency: capture at cycle N with `occ`=0, pop at N+1, `done` at N+2.
- `data_out` sampled only in cycles where `pop[c]` and `ahead[c]==0`.

## Configuration
- `SB_PROTOCOL_CHECK_EN` defined: also sets `err[c]` on push to channel c with `occ[c]==DEPTH`, pop with `occ[c]==0`, and sets `err` of all popping channels when more than one `pop` bit is high in a cycle (shared `data_out` ambiguous).
- Undefined: these events are silently saturated/ignored; `err` reflects only data mismatches.

## Test plan
- NUM_CH=4, DEPTH=8: ch0 push 0x11,0x22, then start+push 0x33; pops return 0x11,0x22,0x33 → `done[0]`=1 cycle after third pop, `err`=0.
- Same, third pop returns 0x34 → `err[0]`=1, `prop_signal`=1, stays high until `rst`=0.
- Tag ch1 and ch3 same cycle (occ 0 and 2), interleaved pops with correct data → `done[1]`, `done[3]` at their own check pops, others 0.
- Capture with occ=3 and same-cycle pop → `ahead`=2; check fires on the 3rd subsequent pop.
- REARM=1: two consecutive tags on ch2 → `done[2]` pulses twice, each one cycle; reset asserted while in WAIT → all outputs 0 immediately.
- With `SB_PROTOCOL_CHECK_EN`: 9 pushes to ch0 at DEPTH=8 → `err[0]`=1; `pop`=4'b0011 → `err[0]`,`err[1]`=1. Without macro: both → `err`=0.
